// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver driven by a 16x oversampling tick.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICKS   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_done,
    output logic                 frame_error
);

    localparam int c_S_MAX = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
    localparam int c_S_W   = (c_S_MAX > 2) ? $clog2(c_S_MAX) : 1;
    localparam int c_N_W   = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_S_W-1:0] c_S_MID   = c_S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_S_W-1:0] c_S_BIT   = c_S_W'(OVERSAMPLE - 1);
    localparam logic [c_S_W-1:0] c_S_STOP  = c_S_W'(SB_TICKS - 1);
    localparam logic [c_S_W-1:0] c_S_ONE   = c_S_W'(1);
    localparam logic [c_N_W-1:0] c_N_LAST  = c_N_W'(DATA_BITS - 1);
    localparam logic [c_N_W-1:0] c_N_ONE   = c_N_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic                 r_rx_meta_q;
    logic                 r_rx_s_q;
    state_t               r_state_q,       w_state_d;
    logic [c_S_W-1:0]     r_s_q,           w_s_d;
    logic [c_N_W-1:0]     r_n_q,           w_n_d;
    logic [DATA_BITS-1:0] r_b_q,           w_b_d;
    logic [DATA_BITS-1:0] r_data_out_q,    w_data_out_d;
    logic                 r_rx_done_q,     w_rx_done_d;
    logic                 r_frame_error_q, w_frame_error_d;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_meta_q <= 1'b1;
            r_rx_s_q    <= 1'b1;
        end else begin
            r_rx_meta_q <= rx;
            r_rx_s_q    <= r_rx_meta_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q       <= ST_IDLE;
            r_s_q           <= '0;
            r_n_q           <= '0;
            r_b_q           <= '0;
            r_data_out_q    <= '0;
            r_rx_done_q     <= 1'b0;
            r_frame_error_q <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_s_q           <= w_s_d;
            r_n_q           <= w_n_d;
            r_b_q           <= w_b_d;
            r_data_out_q    <= w_data_out_d;
            r_rx_done_q     <= w_rx_done_d;
            r_frame_error_q <= w_frame_error_d;
        end
    end

    always_comb begin
        w_state_d       = r_state_q;
        w_s_d           = r_s_q;
        w_n_d           = r_n_q;
        w_b_d           = r_b_q;
        w_data_out_d    = r_data_out_q;
        w_rx_done_d     = 1'b0;
        w_frame_error_d = r_frame_error_q;

        unique case (r_state_q)
            ST_IDLE: begin
                // Start detection does not wait for a tick, so back-to-back
                // frames re-arm on the clock right after the stop tick.
                if (!r_rx_s_q) begin
                    w_state_d = ST_START;
                    w_s_d     = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (r_s_q == c_S_MID) begin
                        if (!r_rx_s_q) begin
                            w_state_d = ST_DATA;
                            w_s_d     = '0;
                            w_n_d     = '0;
                        end else begin
                            w_state_d = ST_IDLE;
                        end
                    end else begin
                        w_s_d = r_s_q + c_S_ONE;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (r_s_q == c_S_BIT) begin
                        w_s_d = '0;
                        w_b_d = {r_rx_s_q, r_b_q[DATA_BITS-1:1]};
                        if (r_n_q == c_N_LAST) begin
                            w_state_d = ST_STOP;
                        end else begin
                            w_n_d = r_n_q + c_N_ONE;
                        end
                    end else begin
                        w_s_d = r_s_q + c_S_ONE;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (r_s_q == c_S_STOP) begin
                        w_data_out_d    = r_b_q;
                        w_frame_error_d = ~r_rx_s_q;
                        w_rx_done_d     = 1'b1;
                        w_state_d       = ST_IDLE;
                    end else begin
                        w_s_d = r_s_q + c_S_ONE;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    assign data_out    = r_data_out_q;
    assign rx_done     = r_rx_done_q;
    assign frame_error = r_frame_error_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx with a scoreboard of sent frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick  = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data_out;
    logic       rx_done;
    logic       frame_error;

    always #5 clock = ~clock;

    uart_rx #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .SB_TICKS  (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .rx         (rx),
        .data_out   (data_out),
        .rx_done    (rx_done),
        .frame_error(frame_error)
    );

    typedef struct {
        logic [7:0] data;
        logic       fe;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        bit         stop_hi;
        bit         exp_fe;
        int         gap;
    } vec_t;

    exp_t sb[$];
    int   checks        = 0;
    int   errors        = 0;
    int   done_count    = 0;
    int   cyc           = 0;
    int   last_start_cyc = 0;
    int   last_done_cyc = 0;
    int   prev_done_cyc = 0;
    bit   tick_en       = 1'b1;
    logic [1:0] div     = 2'd0;
    logic prev_done     = 1'b0;
    exp_t mon_e;

    always @(posedge clock) cyc = cyc + 1;

    // Tick every 4 clocks; changes just after posedge so it is stable at negedge.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (tick_en) begin
                div  = div + 2'd1;
                tick = (div == 2'd0);
            end else begin
                tick = 1'b0;
            end
        end
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic checkr(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    always @(negedge clock) begin
        if (rx_done) begin
            done_count    = done_count + 1;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            check1("done_width", prev_done, 1'b0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: data_out=%02h with no frame outstanding", data_out);
            end else begin
                mon_e = sb.pop_front();
                check8("data_out", data_out, mon_e.data);
                check1("frame_error", frame_error, mon_e.fe);
            end
        end
        prev_done = rx_done;
    end

    task automatic wait_ticks(input int k);
        int c;
        c = 0;
        while (c < k) begin
            @(negedge clock);
            if (tick) c++;
        end
    endtask

    // Bit timing counts ticks, so a tick stall stretches the line accordingly.
    // A low stop bit is released after 12 ticks so the line is idle again
    // before the receiver's next mid-start sample.
    task automatic send_frame(input logic [7:0] d, input bit stop_hi,
                              input bit push, input bit exp_fe);
        exp_t e;
        if (push) begin
            e.data = d;
            e.fe   = exp_fe;
            sb.push_back(e);
        end
        rx = 1'b0;
        last_start_cyc = cyc;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
        rx = stop_hi;
        wait_ticks(12);
        rx = 1'b1;
        wait_ticks(4);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 2000) begin
            @(negedge clock);
            w++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d frames outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[5];
    int   dc0;

    initial begin
        vecs[0] = '{data: 8'h55, stop_hi: 1'b1, exp_fe: 1'b0, gap: 100};
        vecs[1] = '{data: 8'hA3, stop_hi: 1'b1, exp_fe: 1'b0, gap: 0};
        vecs[2] = '{data: 8'h0F, stop_hi: 1'b1, exp_fe: 1'b0, gap: 200};
        vecs[3] = '{data: 8'h3C, stop_hi: 1'b0, exp_fe: 1'b1, gap: 200};
        vecs[4] = '{data: 8'h81, stop_hi: 1'b1, exp_fe: 1'b0, gap: 200};

        repeat (3) @(negedge clock);
        check8("reset_data_out", data_out, 8'h00);
        check1("reset_rx_done", rx_done, 1'b0);
        check1("reset_frame_error", frame_error, 1'b0);
        reset = 1'b0;
        repeat (20) @(negedge clock);

        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_hi, 1'b1, vecs[i].exp_fe);
            drain();
            if (i == 0) checkr("done_latency", last_done_cyc - last_start_cyc, 600, 625);
            if (i == 2) checkr("b2b_spacing", last_done_cyc - prev_done_cyc, 632, 648);
            repeat (vecs[i].gap) @(negedge clock);
        end

        // Short low glitch must be rejected at the mid-start sample.
        dc0 = done_count;
        rx = 1'b0;
        repeat (12) @(negedge clock);
        rx = 1'b1;
        repeat (2000) @(negedge clock);
        checkr("glitch_no_done", done_count, dc0, dc0);
        check8("glitch_data_held", data_out, 8'h81);
        send_frame(8'h96, 1'b1, 1'b1, 1'b0);
        drain();
        repeat (100) @(negedge clock);

        // Reset in the middle of a frame aborts it silently.
        dc0 = done_count;
        fork
            send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
            begin
                wait_ticks(64);
                reset = 1'b1;
                @(negedge clock);
                check8("midreset_data_out", data_out, 8'h00);
                check1("midreset_rx_done", rx_done, 1'b0);
                check1("midreset_frame_error", frame_error, 1'b0);
                reset = 1'b0;
            end
        join
        repeat (100) @(negedge clock);
        checkr("midreset_no_done", done_count, dc0, dc0);
        send_frame(8'hC4, 1'b1, 1'b1, 1'b0);
        drain();
        repeat (100) @(negedge clock);

        // Tick stall mid-frame: receiver state must freeze and then resume.
        dc0 = done_count;
        fork
            send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
            begin
                wait_ticks(80);
                tick_en = 1'b0;
                repeat (500) @(negedge clock);
                tick_en = 1'b1;
            end
        join
        drain();
        checkr("stall_done_count", done_count, dc0 + 1, dc0 + 1);
        check8("stall_data_held", data_out, 8'h5A);
        repeat (50) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
